// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register for {instr, pc}: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Define STAGE_PERF_EN to add the saturating stall_cnt / flush_cnt performance counters.
module pipe_stage_skid #(
   parameter int                DATA_W    = 32,
   parameter int                PC_W      = 32,
   parameter logic [PC_W-1:0]   PC_RST    = 32'h0000_3000,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000
`ifdef STAGE_PERF_EN
   ,
   parameter int                CNT_W     = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [PC_W-1:0]   out_pc
`ifdef STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // State bits are {skid_valid, main_valid}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_t;

   state_t            state, state_n;
   logic              load_main, load_skid, main_from_skid;
   logic              in_fire, out_fire;
   logic [DATA_W-1:0] main_instr, skid_instr;
   logic [PC_W-1:0]   main_pc, skid_pc;
   logic              in_ready_r;

   assign in_ready  = in_ready_r;
   assign out_valid = state[0];
   assign out_instr = state[0] ? main_instr : NOP_INSTR;
   assign out_pc    = main_pc;
   assign in_fire   = in_valid & in_ready_r;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         in_ready_r <= 1'b1;
      end else begin
         state      <= state_n;
         in_ready_r <= ~state_n[1];
      end
   end

   always_comb begin
      state_n        = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_n = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_n   = FULL;
                  load_main = 1'b1;
               end
            end
            FULL: begin
               if (out_fire) begin
                  if (in_fire) load_main = 1'b1;
                  else         state_n   = EMPTY;
               end else if (in_fire) begin
                  state_n   = SKID;
                  load_skid = 1'b1;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_n        = FULL;
                  main_from_skid = 1'b1;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   // Payload registers: only move on load strobes, so flush leaves main_pc intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_instr <= NOP_INSTR;
         main_pc    <= PC_RST;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         if (load_main) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
         end else if (main_from_skid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
         end
         if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
         end
      end
   end

`ifdef STAGE_PERF_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !flush) stall_cnt <= sat_inc(stall_cnt);
         if (flush)                             flush_cnt <= sat_inc(flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid back-pressure, flush and reset-in-SKID.
// With STAGE_PERF_EN the counters are built with CNT_W=4 and their saturation is exercised.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   int          tests = 0;
   int          fails = 0;
`ifdef STAGE_PERF_EN
   logic [3:0]  stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_W(32), .PC_W(32), .PC_RST(32'h0000_3000), .NOP_INSTR(32'h0000_0000)
`ifdef STAGE_PERF_EN
      , .CNT_W(4)
`endif
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it before sampling / driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = 32'hA000_0000 | pc;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0);
      step(); step();
      reset = 1'b0;
      step();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_pc",    out_pc,    32'h3000);
      check("rst_in_ready",  {31'b0, in_ready}, 32'd1);

      // Streaming with out_ready=1: one beat per cycle, 1-cycle latency.
      out_ready = 1'b1;
      drive(1'b1, 32'h3000); step();
      check("str0_valid", {31'b0, out_valid}, 32'd1);
      check("str0_pc",    out_pc,    32'h3000);
      check("str0_instr", out_instr, 32'hA000_3000);
      drive(1'b1, 32'h3004); step();
      check("str1_pc",    out_pc, 32'h3004);
      check("str1_ready", {31'b0, in_ready}, 32'd1);
      drive(1'b1, 32'h3008); step();
      check("str2_pc",    out_pc, 32'h3008);
      check("str2_valid", {31'b0, out_valid}, 32'd1);
      drive(1'b0, 32'h0); step();
      check("drain_valid", {31'b0, out_valid}, 32'd0);
      check("drain_instr", out_instr, 32'h0);
      check("drain_pc",    out_pc,    32'h3008);

      // Back-pressure: second beat goes into the skid entry, third waits upstream.
      out_ready = 1'b0;
      drive(1'b1, 32'h3000); step();
      check("bp_load_pc", out_pc, 32'h3000);
      check("bp_load_rdy", {31'b0, in_ready}, 32'd1);
      drive(1'b1, 32'h3004); step();
      check("bp_skid_rdy", {31'b0, in_ready}, 32'd0);
      check("bp_skid_pc",  out_pc, 32'h3000);
      drive(1'b1, 32'h3008); step();
      check("bp_hold_pc",    out_pc, 32'h3000);
      check("bp_hold_instr", out_instr, 32'hA000_3000);
      check("bp_hold_rdy",   {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1; step();
      check("bp_rel1_pc",  out_pc, 32'h3004);
      check("bp_rel1_rdy", {31'b0, in_ready}, 32'd1);
      step();
      check("bp_rel2_pc",    out_pc, 32'h3008);
      check("bp_rel2_valid", {31'b0, out_valid}, 32'd1);
      drive(1'b0, 32'h0); step();
      check("bp_end_valid", {31'b0, out_valid}, 32'd0);

      // Flush in SKID with a beat presented: everything discarded, main_pc held.
      out_ready = 1'b0;
      drive(1'b1, 32'h3000); step();
      drive(1'b1, 32'h3004); step();
      check("fl_pre_rdy", {31'b0, in_ready}, 32'd0);
      flush = 1'b1; drive(1'b1, 32'h300c); step();
      flush = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b1;
      check("fl_valid", {31'b0, out_valid}, 32'd0);
      check("fl_instr", out_instr, 32'h0);
      check("fl_rdy",   {31'b0, in_ready}, 32'd1);
      check("fl_pc",    out_pc, 32'h3000);
      step();
      check("fl_after1_valid", {31'b0, out_valid}, 32'd0);
      step();
      check("fl_after2_valid", {31'b0, out_valid}, 32'd0);
      check("fl_after2_pc",    out_pc, 32'h3000);

      // Reset wins over flush and in_valid while in SKID.
      out_ready = 1'b0;
      drive(1'b1, 32'h3010); step();
      drive(1'b1, 32'h3014); step();
      step();
      check("rs_pre_rdy", {31'b0, in_ready}, 32'd0);
      check("rs_pre_pc",  out_pc, 32'h3010);
      reset = 1'b1; flush = 1'b1; drive(1'b1, 32'h3018); step();
      reset = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
      check("rs_valid", {31'b0, out_valid}, 32'd0);
      check("rs_pc",    out_pc, 32'h3000);
      check("rs_rdy",   {31'b0, in_ready}, 32'd1);
`ifdef STAGE_PERF_EN
      check("rs_stall_cnt", {28'b0, stall_cnt}, 32'd0);
      check("rs_flush_cnt", {28'b0, flush_cnt}, 32'd0);

      // Counter saturation at 15 with CNT_W=4.
      drive(1'b1, 32'h3020); step();
      drive(1'b0, 32'h0);
      for (int i = 0; i < 20; i++) step();
      check("perf_stall_sat", {28'b0, stall_cnt}, 32'd15);
      flush = 1'b1;
      for (int i = 0; i < 3; i++) step();
      flush = 1'b0;
      check("perf_flush_cnt", {28'b0, flush_cnt}, 32'd3);
      check("perf_stall_kept", {28'b0, stall_cnt}, 32'd15);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
